// File: rtl/nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl
//   Sequencer that lets a single external 4-bit ripple adder perform a
//   WIDTH-bit addition.
//
//   Operation:
//     - Accepts one operand pair (a, b, cin) on a valid/ready handshake.
//     - Sends the operands to the adder one nibble per cycle, LSB nibble
//       first.
//     - Chains each nibble's carry-out into the carry-in of the next nibble.
//     - Collects the nibble sums into a WIDTH-bit result.
//     - Presents the result on a valid/ready output handshake.
//
//   Ports:
//     clock, reset               clock; asynchronous active-high reset
//     io_in_valid / io_in_ready  operand handshake (ready only while idle)
//     io_in_a, io_in_b           WIDTH-bit operands, captured on accept
//     io_in_cin                  carry into the LSB nibble
//     io_add_A/B/Cin             current nibble pair and chained carry,
//                                sent to the adder
//     io_add_Sum/Cout            adder result; combinational, same cycle
//     io_out_valid/io_out_ready  result handshake
//     io_out_sum, io_out_cout    result register and final carry register
//
//   WIDTH must be a multiple of 4 and at least 8.
//   One operation takes NIBBLES run cycles plus one result cycle.
// ---------------------------------------------------------------------------
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_a,
  input  logic [WIDTH-1:0] io_in_b,
  input  logic             io_in_cin,
  output logic [3:0]       io_add_A,
  output logic [3:0]       io_add_B,
  output logic             io_add_Cin,
  input  logic [3:0]       io_add_Sum,
  input  logic             io_add_Cout,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_sum,
  output logic             io_out_cout
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [IDX_W-1:0]          r_idx;
  logic [WIDTH-1:0]          r_a_q;
  logic [WIDTH-1:0]          r_b_q;
  logic [WIDTH-1:0]          r_sum_q;
  logic                      r_carry_q;

  // Nibble views of the operand registers, so the adder inputs are a
  // plain mux selected by the nibble index.
  logic [NIBBLES-1:0][3:0]   w_a_nib;
  logic [NIBBLES-1:0][3:0]   w_b_nib;
  logic                      w_last;
  logic                      w_accept;
  logic                      w_run;

  assign w_a_nib  = r_a_q;
  assign w_b_nib  = r_b_q;
  assign w_last   = (r_idx == IDX_W'(NIBBLES - 1));
  assign w_run    = (r_state == S_RUN);
  assign w_accept = io_in_valid && (r_state == S_IDLE);

  // The result outputs come straight from registers. They keep their value
  // after the result is taken; only io_out_valid says when they are
  // meaningful.
  assign io_out_sum  = r_sum_q;
  assign io_out_cout = r_carry_q;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and handshake / adder outputs.
  // All outputs decode from registered state only, so no io_in_* or
  // io_out_ready input has a combinational path to an output.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    io_in_ready  = 1'b0;
    io_out_valid = 1'b0;
    io_add_A     = 4'd0;
    io_add_B     = 4'd0;
    io_add_Cin   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        io_in_ready = 1'b1;
        if (io_in_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        io_add_A   = w_a_nib[r_idx];
        io_add_B   = w_b_nib[r_idx];
        io_add_Cin = r_carry_q;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        io_out_valid = 1'b1;
        if (io_out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Nibble index: counts 0..NIBBLES-1 during RUN, and wraps to 0 on the
  // last nibble so the next operation starts from a clean index.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx <= '0;
    end else if (w_accept) begin
      r_idx <= '0;
    end else if (w_run) begin
      r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Operand registers.
  // Captured on accept, so the upstream side may change its inputs
  // immediately afterwards.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a_q <= '0;
      r_b_q <= '0;
    end else if (w_accept) begin
      r_a_q <= io_in_a;
      r_b_q <= io_in_b;
    end
  end

  // -------------------------------------------------------------------------
  // Carry register.
  // It holds io_in_cin at the start of an operation and then the
  // inter-nibble carry while running. After the last nibble it holds the
  // final carry-out, which is the io_out_cout result.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_carry_q <= 1'b0;
    end else if (w_accept) begin
      r_carry_q <= io_in_cin;
    end else if (w_run) begin
      r_carry_q <= io_add_Cout;
    end
  end

  // -------------------------------------------------------------------------
  // Result assembly: each RUN cycle writes only the nibble selected by
  // the index.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sum_q <= '0;
    end else if (w_accept) begin
      r_sum_q <= '0;
    end else if (w_run) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (r_idx == IDX_W'(i)) r_sum_q[4*i +: 4] <= io_add_Sum;
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder_ctrl
//   Directed and randomized bench for nibble_serial_adder_ctrl with WIDTH=16.
//   It contains a behavioural 4-bit adder that closes the io_add_* loop.
//   Expected results are hand values or the golden model a+b+cin.
// ---------------------------------------------------------------------------
module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_in_a;
  logic [WIDTH-1:0] io_in_b;
  logic             io_in_cin;
  logic [3:0]       io_add_A;
  logic [3:0]       io_add_B;
  logic             io_add_Cin;
  logic [3:0]       io_add_Sum;
  logic             io_add_Cout;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [WIDTH-1:0] io_out_sum;
  logic             io_out_cout;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .io_in_valid (io_in_valid),
    .io_in_ready (io_in_ready),
    .io_in_a     (io_in_a),
    .io_in_b     (io_in_b),
    .io_in_cin   (io_in_cin),
    .io_add_A    (io_add_A),
    .io_add_B    (io_add_B),
    .io_add_Cin  (io_add_Cin),
    .io_add_Sum  (io_add_Sum),
    .io_add_Cout (io_add_Cout),
    .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready),
    .io_out_sum  (io_out_sum),
    .io_out_cout (io_out_cout)
  );

  // External 4-bit ripple adder stage, combinational.
  assign {io_add_Cout, io_add_Sum} = 5'(io_add_A) + 5'(io_add_B) + 5'(io_add_Cin);

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full operation.
  // Steps:
  //   1. Accept the operand pair.
  //   2. Record io_add_Cin for each RUN cycle.
  //   3. Check the latency and the result.
  //   4. Optionally hold off out_ready for 'hold' cycles.
  //   5. Release the result.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic [15:0] es, input logic ec, input string tag,
                        input int hold, output logic [3:0] cins);
    int n;
    io_in_a      = a;
    io_in_b      = b;
    io_in_cin    = cin;
    io_in_valid  = 1'b1;
    io_out_ready = 1'b0;
    chk({tag, ".in_rdy"}, io_in_ready, 1);
    tick();
    io_in_valid = 1'b0;
    io_in_a     = ~a;          // captured already; changing it must not matter
    io_in_b     = ~b;
    io_in_cin   = ~cin;
    n    = 0;
    cins = 4'd0;
    while (!io_out_valid && n < 16) begin
      if (n < 4) cins[n] = io_add_Cin;
      if (n == 0) begin
        chk({tag, ".addA0"}, io_add_A, a[3:0]);
        chk({tag, ".addB0"}, io_add_B, b[3:0]);
        chk({tag, ".busy"}, io_in_ready, 0);
      end
      tick();
      n++;
    end
    chk({tag, ".lat"},  n, 4);
    chk({tag, ".sum"},  io_out_sum, es);
    chk({tag, ".cout"}, io_out_cout, ec);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, ".hold_vld"}, io_out_valid, 1);
      chk({tag, ".hold_sum"}, io_out_sum, es);
      chk({tag, ".hold_rdy"}, io_in_ready, 0);
    end
    io_out_ready = 1'b1;
    tick();
    io_out_ready = 1'b0;
    chk({tag, ".idle_vld"}, io_out_valid, 0);
    chk({tag, ".idle_rdy"}, io_in_ready, 1);
    chk({tag, ".keep_sum"}, io_out_sum, es);
  endtask

  initial begin
    logic [3:0]  cins;
    int          t1;
    int          t2;
    int          n;
    int          sent;
    int          rcvd;
    int          guard;
    logic        acc;
    logic        dlv;
    logic [16:0] q[$];
    logic [16:0] e;

    reset        = 1'b1;
    io_in_valid  = 1'b0;
    io_in_a      = '0;
    io_in_b      = '0;
    io_in_cin    = 1'b0;
    io_out_ready = 1'b0;
    tick();
    tick();
    chk("rst.in_rdy",  io_in_ready, 1);
    chk("rst.out_vld", io_out_valid, 0);
    chk("rst.sum",     io_out_sum, 0);
    chk("rst.cout",    io_out_cout, 0);
    chk("rst.add",     {io_add_A, io_add_B, io_add_Cin}, 0);
    reset = 1'b0;
    tick();

    // Test 1: basic addition with carry-in.
    run_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, "t1", 0, cins);

    // Test 2: a carry that ripples through every nibble.
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "t2", 0, cins);
    chk("t2.cin_seq", cins, 4'b1110);

    // Test 3: downstream back-pressure held for 5 cycles.
    run_op(16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, "t3", 5, cins);

    // Test 4: asynchronous reset in the middle of RUN, at idx=2.
    io_in_a     = 16'hABCD;
    io_in_b     = 16'h1111;
    io_in_cin   = 1'b0;
    io_in_valid = 1'b1;
    tick();
    io_in_valid = 1'b0;
    tick();
    tick();
    chk("t4.idx2_A", io_add_A, 4'hB);
    reset = 1'b1;
    #1;
    chk("t4.rdy",  io_in_ready, 1);
    chk("t4.vld",  io_out_valid, 0);
    chk("t4.add",  {io_add_A, io_add_B, io_add_Cin}, 0);
    #1;
    reset = 1'b0;
    tick();
    chk("t4.novld", io_out_valid, 0);
    run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, "t4b", 0, cins);

    // Test 5: back-to-back operations with in_valid held high.
    io_out_ready = 1'b1;
    io_in_a      = 16'h8000;
    io_in_b      = 16'h8000;
    io_in_cin    = 1'b0;
    io_in_valid  = 1'b1;
    tick();
    t1        = cyc;
    io_in_a   = 16'h7FFF;
    io_in_b   = 16'h0001;
    n = 0;
    while (!io_out_valid && n < 16) begin
      tick();
      n++;
    end
    chk("t5.sum1",  io_out_sum, 16'h0000);
    chk("t5.cout1", io_out_cout, 1);
    n = 0;
    while (!io_in_ready && n < 16) begin
      tick();
      n++;
    end
    tick();
    t2          = cyc;
    io_in_valid = 1'b0;
    chk("t5.gap", t2 - t1, 6);
    n = 0;
    while (!io_out_valid && n < 16) begin
      tick();
      n++;
    end
    chk("t5.sum2",  io_out_sum, 16'h8000);
    chk("t5.cout2", io_out_cout, 0);
    tick();
    io_out_ready = 1'b0;

    // Test 6: random traffic checked against a scoreboard of a+b+cin.
    sent  = 0;
    rcvd  = 0;
    guard = 0;
    io_in_valid = 1'b0;
    while ((sent < 1000 || q.size() != 0) && guard < 40000) begin
      acc = io_in_valid && io_in_ready;
      dlv = io_out_valid && io_out_ready;
      if (dlv) begin
        if (q.size() == 0) begin
          chk("rnd.extra", 1, 0);
        end else begin
          e = q.pop_front();
          chk("rnd.sum",  io_out_sum, e[15:0]);
          chk("rnd.cout", io_out_cout, e[16]);
          rcvd++;
        end
      end
      if (acc) begin
        q.push_back(17'(io_in_a) + 17'(io_in_b) + 17'(io_in_cin));
        sent++;
      end
      tick();
      guard++;
      if (acc || !io_in_valid) begin
        io_in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
        io_in_a     = 16'($urandom);
        io_in_b     = 16'($urandom);
        io_in_cin   = 1'($urandom_range(0, 1));
      end
      io_out_ready = 1'($urandom_range(0, 1));
    end
    chk("rnd.count", rcvd, 1000);
    chk("rnd.left",  q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
